// File: rtl/zx_ps2_keyboard.sv
// zx_ps2_keyboard
// Converts a raw PS/2 keyboard stream into the ZX Spectrum 8x5 key matrix,
// together with held-level function-key and modifier vectors.
//
// Ports:
//   clk_sys      in   system clock
//   reset_n      in   asynchronous active-low reset
//   ps2_kbd_clk  in   raw PS/2 clock (asynchronous)
//   ps2_kbd_data in   raw PS/2 data (asynchronous)
//   addr[15:0]   in   CPU address, addr[15:8] are active-low half-row selects
//   key_data[4:0] out matrix column read, active low
//   Fn[11:1]     out  F1..F11 held
//   mod[2:0]     out  {Shift, Alt, Ctrl} held
//   frame_err    out  one-cycle pulse on parity, stop-bit or timeout error
module zx_ps2_keyboard #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 224000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_kbd_clk,
    input  logic        ps2_kbd_data,
    input  logic [15:0] addr,
    output logic [4:0]  key_data,
    output logic [11:1] Fn,
    output logic [2:0]  mod,
    output logic        frame_err
);

    localparam int FC_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    // Physical key indices. 0..39 are matrix positions (row*5 + bit); slot 0
    // is LShift (CS) and slot 36 is LCtrl (SS). Extra sources follow.
    localparam logic [5:0] K_RSHIFT = 6'd40;
    localparam logic [5:0] K_RCTRL  = 6'd41;
    localparam logic [5:0] K_BKSP   = 6'd42;
    localparam logic [5:0] K_LEFT   = 6'd43;
    localparam logic [5:0] K_DOWN   = 6'd44;
    localparam logic [5:0] K_UP     = 6'd45;
    localparam logic [5:0] K_RIGHT  = 6'd46;
    localparam logic [5:0] K_ESC    = 6'd47;
    localparam logic [5:0] K_LALT   = 6'd48;
    localparam logic [5:0] K_RALT   = 6'd49;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Returns {hit, index} of the physical key addressed by a scancode.
    function automatic logic [6:0] key_lookup(input logic ext, input logic [7:0] code);
        logic [6:0] v;
        v = 7'd0;
        if (ext) begin
            // E0 12 / E0 59 (fake shifts) deliberately fall through to no hit.
            case (code)
                8'h14:   v = {1'b1, K_RCTRL};
                8'h11:   v = {1'b1, K_RALT};
                8'h6B:   v = {1'b1, K_LEFT};
                8'h72:   v = {1'b1, K_DOWN};
                8'h75:   v = {1'b1, K_UP};
                8'h74:   v = {1'b1, K_RIGHT};
                default: v = 7'd0;
            endcase
        end else begin
            case (code)
                8'h12: v = {1'b1, 6'd0};   // LShift -> CS
                8'h1A: v = {1'b1, 6'd1};   // Z
                8'h22: v = {1'b1, 6'd2};   // X
                8'h21: v = {1'b1, 6'd3};   // C
                8'h2A: v = {1'b1, 6'd4};   // V
                8'h1C: v = {1'b1, 6'd5};   // A
                8'h1B: v = {1'b1, 6'd6};   // S
                8'h23: v = {1'b1, 6'd7};   // D
                8'h2B: v = {1'b1, 6'd8};   // F
                8'h34: v = {1'b1, 6'd9};   // G
                8'h15: v = {1'b1, 6'd10};  // Q
                8'h1D: v = {1'b1, 6'd11};  // W
                8'h24: v = {1'b1, 6'd12};  // E
                8'h2D: v = {1'b1, 6'd13};  // R
                8'h2C: v = {1'b1, 6'd14};  // T
                8'h16: v = {1'b1, 6'd15};  // 1
                8'h1E: v = {1'b1, 6'd16};  // 2
                8'h26: v = {1'b1, 6'd17};  // 3
                8'h25: v = {1'b1, 6'd18};  // 4
                8'h2E: v = {1'b1, 6'd19};  // 5
                8'h45: v = {1'b1, 6'd20};  // 0
                8'h46: v = {1'b1, 6'd21};  // 9
                8'h3E: v = {1'b1, 6'd22};  // 8
                8'h3D: v = {1'b1, 6'd23};  // 7
                8'h36: v = {1'b1, 6'd24};  // 6
                8'h4D: v = {1'b1, 6'd25};  // P
                8'h44: v = {1'b1, 6'd26};  // O
                8'h43: v = {1'b1, 6'd27};  // I
                8'h3C: v = {1'b1, 6'd28};  // U
                8'h35: v = {1'b1, 6'd29};  // Y
                8'h5A: v = {1'b1, 6'd30};  // Enter
                8'h4B: v = {1'b1, 6'd31};  // L
                8'h42: v = {1'b1, 6'd32};  // K
                8'h3B: v = {1'b1, 6'd33};  // J
                8'h33: v = {1'b1, 6'd34};  // H
                8'h29: v = {1'b1, 6'd35};  // Space
                8'h14: v = {1'b1, 6'd36};  // LCtrl -> SS
                8'h3A: v = {1'b1, 6'd37};  // M
                8'h31: v = {1'b1, 6'd38};  // N
                8'h32: v = {1'b1, 6'd39};  // B
                8'h59: v = {1'b1, K_RSHIFT};
                8'h66: v = {1'b1, K_BKSP};
                8'h76: v = {1'b1, K_ESC};
                8'h11: v = {1'b1, K_LALT};
                default: v = 7'd0;
            endcase
        end
        return v;
    endfunction

    // Returns {hit, F-number 1..11}. F12 and extended codes never hit.
    function automatic logic [4:0] fn_lookup(input logic ext, input logic [7:0] code);
        logic [4:0] v;
        v = 5'd0;
        if (!ext) begin
            case (code)
                8'h05:   v = {1'b1, 4'd1};
                8'h06:   v = {1'b1, 4'd2};
                8'h04:   v = {1'b1, 4'd3};
                8'h0C:   v = {1'b1, 4'd4};
                8'h03:   v = {1'b1, 4'd5};
                8'h0B:   v = {1'b1, 4'd6};
                8'h83:   v = {1'b1, 4'd7};
                8'h0A:   v = {1'b1, 4'd8};
                8'h01:   v = {1'b1, 4'd9};
                8'h09:   v = {1'b1, 4'd10};
                8'h78:   v = {1'b1, 4'd11};
                default: v = 5'd0;
            endcase
        end
        return v;
    endfunction

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_clk_filt;
    logic [FC_W-1:0] r_fcnt;
    logic            w_bit_edge;

    state_t          r_state;
    logic [2:0]      r_bitcnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_shift;
    logic            r_byte_vld;
    logic            r_frame_err;

    logic            r_ext, r_rel;
    logic [2:0]      r_skip;
    logic [49:0]     r_keys;
    logic [11:1]     r_fn;

    logic [6:0]      w_key_hit;
    logic [4:0]      w_fn_hit;
    logic [7:0][4:0] w_base;
    logic [7:0][4:0] w_mat;
    logic [4:0]      w_kd;
    logic            w_unused;

    assign w_unused = ^addr[7:0];

    // Input synchronisers and clock glitch filter
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_filt <= 1'b1;
            r_fcnt     <= '0;
        end else begin
            r_clk_s1 <= ps2_kbd_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_kbd_data;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 != r_clk_filt) begin
                if (r_fcnt == FC_W'(FILTER_LEN - 1)) begin
                    r_clk_filt <= r_clk_s2;
                    r_fcnt     <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // The cycle on which the filtered clock falls
    assign w_bit_edge = r_clk_filt && !r_clk_s2 && (r_fcnt == FC_W'(FILTER_LEN - 1));

    // Receiver FSM
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= 3'd0;
            r_to_cnt    <= '0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state != ST_IDLE && !w_bit_edge) begin
                if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    r_state     <= ST_IDLE;
                    r_frame_err <= 1'b1;
                    r_to_cnt    <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
            if (w_bit_edge) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state  <= ST_DATA;
                            r_bitcnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
                            r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        if (^{r_shift, r_dat_s2}) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_frame_err <= 1'b1;
                        end
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (r_dat_s2)
                            r_byte_vld <= 1'b1;
                        else
                            r_frame_err <= 1'b1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Data shift register, LSB first; holds the byte until the next frame
    always_ff @(posedge clk_sys) begin
        if (w_bit_edge && r_state == ST_DATA)
            r_shift <= {r_dat_s2, r_shift[7:1]};
    end

    assign w_key_hit = key_lookup(r_ext, r_shift);
    assign w_fn_hit  = fn_lookup(r_ext, r_shift);

    // Scancode decoder with prefix tracking
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ext  <= 1'b0;
            r_rel  <= 1'b0;
            r_skip <= 3'd0;
            r_keys <= '0;
            r_fn   <= '0;
        end else if (r_byte_vld) begin
            if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
            end else if (r_shift == 8'hE1) begin
                r_skip <= 3'd7;
                r_ext  <= 1'b0;
                r_rel  <= 1'b0;
            end else if (r_shift == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
                r_rel <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
                if (w_key_hit[6])
                    r_keys[w_key_hit[5:0]] <= ~r_rel;
                if (w_fn_hit[4])
                    r_fn[w_fn_hit[3:0]] <= ~r_rel;
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_row
        assign w_base[g] = r_keys[g*5 +: 5];
    end

    // Fold the extra physical sources into their matrix positions
    always_comb begin
        w_mat       = w_base;
        w_mat[0][0] = r_keys[0] | r_keys[K_RSHIFT] | r_keys[K_BKSP] | r_keys[K_LEFT]
                    | r_keys[K_DOWN] | r_keys[K_UP] | r_keys[K_RIGHT] | r_keys[K_ESC];
        w_mat[7][1] = w_base[7][1] | r_keys[K_RCTRL];
        w_mat[4][0] = w_base[4][0] | r_keys[K_BKSP];
        w_mat[3][4] = w_base[3][4] | r_keys[K_LEFT];
        w_mat[4][4] = w_base[4][4] | r_keys[K_DOWN];
        w_mat[4][3] = w_base[4][3] | r_keys[K_UP];
        w_mat[4][2] = w_base[4][2] | r_keys[K_RIGHT];
        w_mat[7][0] = w_base[7][0] | r_keys[K_ESC];
    end

    // Half-row read: every selected row can pull a column low
    always_comb begin
        w_kd = 5'h1F;
        for (int r = 0; r < 8; r++) begin
            if (!addr[8+r])
                w_kd = w_kd & ~w_mat[r];
        end
    end

    assign key_data  = w_kd;
    assign Fn        = r_fn;
    assign mod       = {r_keys[0] | r_keys[K_RSHIFT],
                        r_keys[K_LALT] | r_keys[K_RALT],
                        r_keys[36] | r_keys[K_RCTRL]};
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_zx_ps2_keyboard.sv
`timescale 1ns/1ps
module tb_zx_ps2_keyboard;

    localparam int HP = 30;   // PS/2 half-period in clk_sys cycles
    localparam int TO = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_c = 1'b1;
    logic        ps2_d = 1'b1;
    logic [15:0] addr = 16'hFFFF;
    logic [4:0]  key_data;
    logic [11:1] fn;
    logic [2:0]  mod;
    logic        frame_err;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int err_w = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [4:0]  kd;
        logic [10:0] f;
        logic [2:0]  m;
        int          e;
    } chk_t;

    chk_t exp_q[$];

    zx_ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .clk_sys(clk), .reset_n(rst_n), .ps2_kbd_clk(ps2_c), .ps2_kbd_data(ps2_d),
        .addr(addr), .key_data(key_data), .Fn(fn), .mod(mod), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // frame_err monitor: counts pulses and checks each is one cycle wide
    initial begin
        forever begin
            @(negedge clk);
            if (frame_err) begin
                err_w++;
            end else if (err_w > 0) begin
                tests++;
                if (err_w != 1) begin
                    fails++;
                    $display("FAIL frame_err_width: got %0d cycles, expected 1", err_w);
                end
                err_cnt++;
                err_w = 0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        chk_t c;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                tests++;
                if (key_data !== c.kd || fn !== c.f || mod !== c.m || err_cnt != c.e) begin
                    fails++;
                    $display("FAIL %s: addr=%h key_data=%h/%h Fn=%h/%h mod=%b/%b errs=%0d/%0d (got/expected)",
                             c.name, c.a, key_data, c.kd, fn, c.f, mod, c.m, err_cnt, c.e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] a, input logic [4:0] kd,
                       input logic [10:0] f, input logic [2:0] m, input int e);
        chk_t c;
        @(posedge clk);
        addr = a;
        c.name = nm; c.a = a; c.kd = kd; c.f = f; c.m = m; c.e = e;
        exp_q.push_back(c);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s: monitor did not sample within 50 cycles, expected key_data=%h", nm, kd);
            exp_q.delete();
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_d = b;
        repeat (HP/2) @(posedge clk);
        ps2_c = 1'b0;
        repeat (HP) @(posedge clk);
        ps2_c = 1'b1;
        repeat (HP/2) @(posedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input logic par_ok, input logic stop, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
        if (nbits == 8) begin
            ps2_bit(par_ok ? ~^b : ^b);
            ps2_bit(stop);
        end
        ps2_d = 1'b1;
        repeat (40) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        frame(b, 1'b1, 1'b1, 8);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);

        chk("rst_fefe", 16'hFEFE, 5'h1F, 11'h000, 3'b000, 0);
        chk("rst_all",  16'h00FE, 5'h1F, 11'h000, 3'b000, 0);
        chk("rst_none", 16'hFFFF, 5'h1F, 11'h000, 3'b000, 0);

        send(8'h1C);
        chk("a_press", 16'hFDFE, 5'h1E, 11'h000, 3'b000, 0);
        chk("a_all",   16'h00FE, 5'h1E, 11'h000, 3'b000, 0);
        send(8'hF0); send(8'h1C);
        chk("a_rel",   16'hFDFE, 5'h1F, 11'h000, 3'b000, 0);

        send(8'h12);
        chk("lshift",  16'hFEFE, 5'h1E, 11'h000, 3'b100, 0);
        send(8'h1A);
        chk("cs_z",    16'hFEFE, 5'h1C, 11'h000, 3'b100, 0);
        send(8'hF0); send(8'h12);
        chk("z_only",  16'hFEFE, 5'h1D, 11'h000, 3'b000, 0);
        send(8'hF0); send(8'h1A);
        chk("z_rel",   16'hFEFE, 5'h1F, 11'h000, 3'b000, 0);

        send(8'hE0); send(8'h75);
        chk("up_cs",   16'hFEFE, 5'h1E, 11'h000, 3'b000, 0);
        chk("up_7",    16'hEFFE, 5'h17, 11'h000, 3'b000, 0);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_rel_cs", 16'hFEFE, 5'h1F, 11'h000, 3'b000, 0);
        chk("up_rel_7",  16'hEFFE, 5'h1F, 11'h000, 3'b000, 0);

        send(8'h12); send(8'hE0); send(8'h75);
        chk("sh_up_7",   16'hEFFE, 5'h17, 11'h000, 3'b100, 0);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("sh_uprel_cs", 16'hFEFE, 5'h1E, 11'h000, 3'b100, 0);
        chk("sh_uprel_7",  16'hEFFE, 5'h1F, 11'h000, 3'b100, 0);
        send(8'hF0); send(8'h12);
        chk("sh_rel",    16'hFEFE, 5'h1F, 11'h000, 3'b000, 0);

        send(8'hE0); send(8'h12);
        chk("fake_shift", 16'hFEFE, 5'h1F, 11'h000, 3'b000, 0);
        send(8'hE0); send(8'hF0); send(8'h12);

        send(8'h66);
        chk("bksp_cs",  16'hFEFE, 5'h1E, 11'h000, 3'b000, 0);
        chk("bksp_0",   16'hEFFE, 5'h1E, 11'h000, 3'b000, 0);
        send(8'hF0); send(8'h66);
        chk("bksp_rel", 16'hEEFE, 5'h1F, 11'h000, 3'b000, 0);
        send(8'h76);
        chk("esc",      16'h7EFE, 5'h1E, 11'h000, 3'b000, 0);
        chk("esc_sp",   16'h7FFE, 5'h1E, 11'h000, 3'b000, 0);
        send(8'hF0); send(8'h76);
        chk("esc_rel",  16'h7EFE, 5'h1F, 11'h000, 3'b000, 0);

        frame(8'h1C, 1'b0, 1'b1, 8);
        chk("par_err",  16'hFDFE, 5'h1F, 11'h000, 3'b000, 1);
        frame(8'h1C, 1'b1, 1'b0, 8);
        chk("stop_err", 16'hFDFE, 5'h1F, 11'h000, 3'b000, 2);
        frame(8'h1C, 1'b1, 1'b1, 4);
        repeat (TO + 200) @(posedge clk);
        chk("timeout",  16'hFDFE, 5'h1F, 11'h000, 3'b000, 3);
        send(8'h29);
        chk("space",    16'h7FFE, 5'h1E, 11'h000, 3'b000, 3);
        send(8'hF0); send(8'h29);

        send(8'h0A);
        chk("f8",       16'hFFFF, 5'h1F, 11'h080, 3'b000, 3);
        send(8'h14);
        chk("lctrl",    16'h7FFE, 5'h1D, 11'h080, 3'b001, 3);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("pause",    16'h7FFE, 5'h1D, 11'h080, 3'b001, 3);
        send(8'h07);
        chk("f12",      16'hFFFF, 5'h1F, 11'h080, 3'b001, 3);
        send(8'hF0); send(8'h0A); send(8'hF0); send(8'h14);
        chk("fn_mod_rel", 16'h7FFE, 5'h1F, 11'h000, 3'b000, 3);
        send(8'hE0); send(8'h14);
        chk("rctrl",    16'h7FFE, 5'h1D, 11'h000, 3'b001, 3);
        send(8'h11);
        chk("lalt",     16'hFFFF, 5'h1F, 11'h000, 3'b011, 3);
        send(8'hE0); send(8'hF0); send(8'h14); send(8'hF0); send(8'h11);
        chk("ctl_alt_rel", 16'h7FFE, 5'h1F, 11'h000, 3'b000, 3);

        send(8'h1C); send(8'h0A); send(8'h12);
        chk("pre_rst",  16'hFDFE, 5'h1E, 11'h080, 3'b100, 3);
        frame(8'h16, 1'b1, 1'b1, 3);
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(posedge clk);
        chk("post_rst_all", 16'h00FE, 5'h1F, 11'h000, 3'b000, 3);
        send(8'h16);
        chk("one",      16'hF7FE, 5'h1E, 11'h000, 3'b000, 3);
        chk("one_only", 16'hFDFE, 5'h1F, 11'h000, 3'b000, 3);

        repeat (10) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
